// File: rtl/cpu_init_pkg.sv
// Shared command codes, FSM states, payload lengths and target widths for the
// CPU init loader.
package cpu_init_pkg;

  localparam logic [7:0] CMD_BTB   = 8'h01;
  localparam logic [7:0] CMD_BHT   = 8'h02;
  localparam logic [7:0] CMD_REG   = 8'h03;
  localparam logic [7:0] CMD_START = 8'h04;
  localparam logic [7:0] CMD_STOP  = 8'h05;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;
  typedef enum logic [1:0] {TGT_BTB, TGT_BHT, TGT_REG} target_t;

  localparam int BTB_BYTES = 5;
  localparam int BHT_BYTES = 1;
  localparam int REG_BYTES = 4;

  localparam int BTB_W      = 40;
  localparam int BHT_W      = 2;
  localparam int REG_W      = 32;
  localparam int TBL_ADDR_W = 8;
  localparam int REG_ADDR_W = 5;

  localparam int SHIFT_W = 40;
  localparam int CNT_W   = 3;

  function automatic logic [CNT_W-1:0] payload_len(input target_t tgt);
    // NOTE: a default arm keeps the decode total, so no path is left unassigned
    // and no latch or X can leak out of a combinational decode.
    case (tgt)
      TGT_BTB: return CNT_W'(BTB_BYTES);
      TGT_BHT: return CNT_W'(BHT_BYTES);
      default: return CNT_W'(REG_BYTES);
    endcase
  endfunction

endpackage

// File: rtl/init_byte_shifter.sv
// MSB-first byte shift register with a remaining-byte counter; done marks the
// shift that completes the payload. Shared by the BTB, BHT and REG targets.
module init_byte_shifter
  import cpu_init_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [CNT_W-1:0]   load_len,
  input  logic               shift,
  input  logic [7:0]         byte_in,
  output logic [SHIFT_W-1:0] data_next,
  output logic               done
);

  logic [SHIFT_W-1:0] data;
  logic [CNT_W-1:0]   remaining;

  // Value the register takes on this shift; the top captures it on the last byte.
  assign data_next = {data[SHIFT_W-9:0], byte_in};
  assign done      = shift && (remaining == CNT_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      data      <= '0;
      remaining <= '0;
    end else if (load) begin
      data      <= '0;
      remaining <= load_len;
    end else if (shift && remaining != '0) begin
      data      <= data_next;
      remaining <= remaining - CNT_W'(1);
    end
  end

endmodule

// File: rtl/cpu_init_loader.sv
// Byte-stream command loader driving the CPU's BTB/BHT/register init ports,
// holding each completed write with rst_switch high for HOLD_CYCLES cycles.
module cpu_init_loader
  import cpu_init_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic [TBL_ADDR_W-1:0] btb_addr,
  output logic [BTB_W-1:0]      btb_init,
  output logic [TBL_ADDR_W-1:0] bht_addr,
  output logic [BHT_W-1:0]      bht_init,
  output logic [REG_ADDR_W-1:0] reg_addr,
  output logic [REG_W-1:0]      reg_init,
  output logic                  rst_switch,
  output logic                  start_switch,
  output logic                  busy,
  output logic                  err
);

  localparam int HCW = $clog2(HOLD_CYCLES);

  state_t             state;
  target_t            tgt;
  logic [HCW-1:0]     hold_cnt;
  logic               fire;
  logic               sh_load;
  logic               sh_shift;
  logic               sh_done;
  logic [SHIFT_W-1:0] sh_next;

  assign fire     = in_valid && in_ready;
  assign sh_load  = fire && (state == ADDR);
  assign sh_shift = fire && (state == DATA);

  init_byte_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .load_len  (payload_len(tgt)),
    .shift     (sh_shift),
    .byte_in   (in_data),
    .data_next (sh_next),
    .done      (sh_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tgt          <= TGT_BTB;
      hold_cnt     <= '0;
      btb_addr     <= '0;
      btb_init     <= '0;
      bht_addr     <= '0;
      bht_init     <= '0;
      reg_addr     <= '0;
      reg_init     <= '0;
      rst_switch   <= 1'b0;
      start_switch <= 1'b0;
      err          <= 1'b0;
      in_ready     <= 1'b1;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (fire) begin
            case (in_data)
              CMD_BTB, CMD_BHT, CMD_REG: begin
                tgt          <= (in_data == CMD_BTB) ? TGT_BTB :
                                (in_data == CMD_BHT) ? TGT_BHT : TGT_REG;
                state        <= ADDR;
                busy         <= 1'b1;
                // The CPU must not run while its tables are rewritten.
                start_switch <= 1'b0;
              end
              CMD_START: start_switch <= 1'b1;
              CMD_STOP:  start_switch <= 1'b0;
              default:   err          <= 1'b1;
            endcase
          end
        end
        ADDR: begin
          if (fire) begin
            case (tgt)
              TGT_BTB: btb_addr <= in_data;
              TGT_BHT: bht_addr <= in_data;
              default: reg_addr <= in_data[REG_ADDR_W-1:0];
            endcase
            state <= DATA;
          end
        end
        DATA: begin
          if (sh_done) begin
            case (tgt)
              TGT_BTB: btb_init <= sh_next[BTB_W-1:0];
              TGT_BHT: bht_init <= sh_next[BHT_W-1:0];
              default: reg_init <= sh_next[REG_W-1:0];
            endcase
            state      <= HOLD;
            hold_cnt   <= HCW'(HOLD_CYCLES - 1);
            rst_switch <= 1'b1;
            in_ready   <= 1'b0;
          end
        end
        HOLD: begin
          // busy stays high for one settle cycle after rst_switch drops.
          if (hold_cnt == '0) begin
            state      <= IDLE;
            rst_switch <= 1'b0;
            in_ready   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - HCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
